// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word request per cycle under a credit limit.
// Responses land in a show-ahead prefetch FIFO that decode pops; redirects flush it.
module instr_fetch_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  // The credit rule must never let a response arrive at a full buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == FULL_C)));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count == {CW{1'b0}})));

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    (count <= FULL_C));

endmodule

module instr_fetch #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_gnt,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [31:0]                instr_data,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] inflight_addr_r;
  logic              inflight_r;
  logic [CW-1:0]     count_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [31:0]       data_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];

  logic              req_s;
  logic              valid_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic [CW:0]       credit_s;
  logic [CW-1:0]     count_nxt_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Request gating: buffered entries plus the pending response consume credit
  always_comb begin
    credit_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
    if (rst || redirect_valid) begin
      req_s = 1'b0;
    end else if (credit_s < DEPTH_C) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  // Head is hidden from decode during reset and redirect cycles
  always_comb begin
    if (rst || redirect_valid) begin
      valid_s = 1'b0;
    end else begin
      valid_s = (count_r != {CW{1'b0}});
    end
  end

  assign accept_s = req_s & imem_gnt;
  assign push_s   = inflight_r & ~redirect_valid;
  assign pop_s    = valid_s & instr_ready;

  // Occupancy update for the push/pop combinations
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Program counter and the single outstanding response tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r            <= {ADDR_W{1'b0}};
      inflight_r      <= 1'b0;
      inflight_addr_r <= {ADDR_W{1'b0}};
    end else if (redirect_valid) begin
      pc_r       <= redirect_addr;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= accept_s;
      if (accept_s) begin
        pc_r            <= pc_r + ADDR_W'(1);
        inflight_addr_r <= pc_r;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
    end else begin
      count_r <= count_nxt_s;
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Entry storage, written only when a response is kept
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      data_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]   <= inflight_addr_r;
    end
  end

  assign imem_req    = req_s;
  assign imem_addr   = pc_r;
  assign instr_valid = valid_s;
  assign instr_data  = data_mem_r[rd_ptr_r];
  assign instr_pc    = pc_mem_r[rd_ptr_r];
  assign count       = count_r;

  instr_fetch_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_r)
  );

endmodule
